// File: rtl/mealy_1011_detector.sv
// ============================================================================
//  Module   : mealy_1011_detector
//  Function : Mealy detector flagging each serial 1-0-1-1 on din (oldest first)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mealy_1011_detector #(
  parameter bit OVERLAP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= din ? S1   : IDLE;
        S1:      state <= din ? S1   : S10;
        S10:     state <= din ? S101 : IDLE;
        // A hit either restarts cleanly or keeps its final '1' as a new prefix.
        S101:    state <= din ? (OVERLAP ? S1 : IDLE) : S10;
        default: state <= IDLE;
      endcase
    end
  end

  assign out = (state == S101) & din & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_mealy_1011_detector.sv
// ============================================================================
//  Module   : tb_mealy_1011_detector
//  Function : Self-checking bench for mealy_1011_detector, both OVERLAP modes
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mealy_1011_detector;

  logic clk;
  logic rst;
  logic din;
  logic out_n;
  logic out_o;

  int errors = 0;
  int checks = 0;

  // Reference: last bits seen since the most recent restart point.
  logic [3:0] hist_n, hist_o;
  int         cnt_n, cnt_o;

  mealy_1011_detector #(.OVERLAP(1'b0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .din (din),
    .out (out_n)
  );

  mealy_1011_detector #(.OVERLAP(1'b1)) u_dut_o (
    .clk (clk),
    .rst (rst),
    .din (din),
    .out (out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_hit(input logic [3:0] hist, input int cnt, input logic b);
    logic [3:0] win;
    win = {hist[2:0], b};
    return (cnt >= 3) && (win == 4'b1011);
  endfunction

  // Present one bit (and reset level), check both outputs, then let the edge pass.
  task automatic step(input logic b, input logic r, input string tag);
    logic exp_n, exp_o;
    @(negedge clk);
    din = b;
    rst = r;
    #2;
    exp_n = !r && is_hit(hist_n, cnt_n, b);
    exp_o = !r && is_hit(hist_o, cnt_o, b);
    check_bit({tag, "/ovl0"}, out_n, exp_n);
    check_bit({tag, "/ovl1"}, out_o, exp_o);
    if (r) begin
      cnt_n = 0;
      cnt_o = 0;
      hist_n = '0;
      hist_o = '0;
    end else begin
      hist_n = {hist_n[2:0], b};
      hist_o = {hist_o[2:0], b};
      cnt_n  = (cnt_n < 4) ? cnt_n + 1 : 4;
      cnt_o  = (cnt_o < 4) ? cnt_o + 1 : 4;
      if (exp_n) cnt_n = 0;
    end
    @(posedge clk);
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0, tag);
  endtask

  task automatic expect_now(input string tag, input logic en, input logic eo);
    check_bit({tag, "/ovl0"}, out_n, en);
    check_bit({tag, "/ovl1"}, out_o, eo);
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b1;
    hist_n = '0;
    hist_o = '0;
    cnt_n = 0;
    cnt_o = 0;

    // Reset with din held high, then release with din low.
    step(1'b1, 1'b1, "reset_din1");
    step(1'b1, 1'b1, "reset_din1b");
    step(1'b0, 1'b0, "release_din0");
    step(1'b0, 1'b0, "release_din0b");

    // Basic pattern; also confirm the pulse position explicitly.
    step(1'b1, 1'b1, "rst");
    step(1'b1, 1'b0, "basic_b1");
    step(1'b0, 1'b0, "basic_b2");
    step(1'b1, 1'b0, "basic_b3");
    @(negedge clk);
    din = 1'b1;
    rst = 1'b0;
    #2;
    expect_now("basic_b4_abs", 1'b1, 1'b1);
    @(posedge clk);
    hist_n = '0; cnt_n = 0;
    hist_o = 4'b1011; cnt_o = 4;

    // Overlap stream: ovl0 pulses at bit 4 only, ovl1 at bits 4 and 7.
    step(1'b1, 1'b1, "rst");
    stream(16'b1011011, 7, "overlap");

    // Near misses, pulse only on bit 8.
    step(1'b1, 1'b1, "rst");
    stream(16'b00101011, 8, "nearmiss");

    // Two separated hits.
    step(1'b1, 1'b1, "rst");
    stream(16'b10111011, 8, "twohits");

    // Reset while sitting in S101 with din=1: out must be suppressed.
    step(1'b1, 1'b1, "rst");
    stream(16'b101, 3, "pre_s101");
    step(1'b1, 1'b1, "rst_in_s101");
    stream(16'b1011, 4, "after_rst");
    step(1'b1, 1'b1, "rst");
    stream(16'b101, 3, "pre_s101b");
    step(1'b1, 1'b1, "rst_in_s101b");
    step(1'b1, 1'b0, "post_rst_1");
    step(1'b1, 1'b0, "post_rst_2");

    // Random stream with sparse resets; bias toward 1s to hit the pattern often.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
